// File: rtl/leiwand_rv32_wb_uart_tx.sv
// Wishbone-pipelined UART transmitter: bytes written to TXDATA go through a small
// FIFO and leave on o_tx as 8N1 frames at a programmable bit period.
module leiwand_rv32_wb_uart_tx #(
   parameter int unsigned MEM_WIDTH        = 32,
   parameter int unsigned FIFO_DEPTH       = 8,
   parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd868
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           i_wb_addr,
   input  logic [MEM_WIDTH-1:0] i_wb_data,
   output logic [MEM_WIDTH-1:0] o_wb_data,
   input  logic                 i_wb_we,
   input  logic                 i_wb_stb,
   output logic                 o_wb_ack,
   input  logic                 i_wb_cyc,
   output logic                 o_wb_stall,
   output logic                 o_tx
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e               state_q, state_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [15:0]          lat_q, lat_d;
   logic [15:0]          baud_q, baud_d;
   logic [2:0]           idx_q, idx_d;
   logic [7:0]           shreg_q, shreg_d;
   logic                 tx_q, tx_d;
   logic                 ack_q, ack_d;
   logic [MEM_WIDTH-1:0] rdata_q, rdata_d;
   logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic [7:0]           mem_q [FIFO_DEPTH];

   logic req, push, push_ok, pop, full, empty, bit_end;
   logic unused_data;

   assign unused_data = ^i_wb_data[MEM_WIDTH-1:16];
   assign full        = (count_q == CW'(FIFO_DEPTH));
   assign empty       = (count_q == '0);
   assign bit_end     = (cnt_q == 16'd1);
   assign req         = i_wb_cyc & i_wb_stb;

   // Bus decode: read data is captured from pre-edge state and shown only with the ack.
   always_comb begin
      push    = 1'b0;
      baud_d  = baud_q;
      rdata_d = '0;
      ack_d   = req;
      if (req) begin
         if (i_wb_we) begin
            unique case (i_wb_addr)
               2'd0:    push = 1'b1;
               2'd2:    baud_d = (i_wb_data[15:0] == 16'd0) ? 16'd1 : i_wb_data[15:0];
               default: ;
            endcase
         end else begin
            unique case (i_wb_addr)
               2'd0: rdata_d[MEM_WIDTH-1] = full;
               2'd1: begin
                  rdata_d[0]       = empty;
                  rdata_d[1]       = full;
                  rdata_d[2]       = (state_q != StIdle);
                  rdata_d[8 +: CW] = count_q;
               end
               2'd2: rdata_d[15:0] = baud_q;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - 16'd1;
      lat_d   = lat_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            tx_d  = 1'b1;
            cnt_d = cnt_q;
            if (!empty) begin
               pop     = 1'b1;
               shreg_d = mem_q[rptr_q];
               lat_d   = baud_q;
               cnt_d   = baud_q;
               state_d = StStart;
               tx_d    = 1'b0;
            end
         end
         StStart: begin
            if (bit_end) begin
               cnt_d   = lat_q;
               idx_d   = 3'd0;
               tx_d    = shreg_q[0];
               state_d = StData;
            end
         end
         StData: begin
            if (bit_end) begin
               cnt_d = lat_q;
               if (idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = StStop;
               end else begin
                  idx_d = idx_q + 3'd1;
                  tx_d  = shreg_q[idx_q + 3'd1];
               end
            end
         end
         StStop: begin
            if (bit_end) begin
               // Back-to-back frames: restart directly without passing through idle.
               if (!empty) begin
                  pop     = 1'b1;
                  shreg_d = mem_q[rptr_q];
                  lat_d   = baud_q;
                  cnt_d   = baud_q;
                  tx_d    = 1'b0;
                  state_d = StStart;
               end else begin
                  tx_d    = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      push_ok = push & (~full | pop);
      wptr_d  = push_ok ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
      count_d = count_q;
      if (push_ok && !pop) count_d = count_q + CW'(1);
      else if (!push_ok && pop) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q] <= i_wb_data[7:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         lat_q   <= DEFAULT_BAUD_DIV;
         baud_q  <= DEFAULT_BAUD_DIV;
         idx_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
         ack_q   <= 1'b0;
         rdata_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   assign o_wb_ack   = ack_q;
   assign o_wb_data  = rdata_q;
   assign o_wb_stall = 1'b0;
   assign o_tx       = tx_q;

endmodule

// File: tb/tb_leiwand_rv32_wb_uart_tx.sv
// Bench for leiwand_rv32_wb_uart_tx: a frame-level model (byte queue plus elapsed-cycle
// counter) predicts every output each cycle; directed literals pin the model.
module tb_leiwand_rv32_wb_uart_tx;
   localparam int D = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        we = 1'b0, stb = 1'b0, cyc = 1'b0;
   logic        ack, stall, tx;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   leiwand_rv32_wb_uart_tx #(
      .MEM_WIDTH(32), .FIFO_DEPTH(D), .DEFAULT_BAUD_DIV(16'd868)
   ) dut (
      .clk(clk), .reset(reset), .i_wb_addr(addr), .i_wb_data(wdata), .o_wb_data(rdata),
      .i_wb_we(we), .i_wb_stb(stb), .o_wb_ack(ack), .i_wb_cyc(cyc), .o_wb_stall(stall),
      .o_tx(tx)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 30) $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: queued bytes, current frame byte, its bit period and cycles elapsed.
   logic [7:0]  mq[$];
   logic [7:0]  cur;
   int          baud, lat, e, k;
   bit          busy, mvalid;
   bit          ack_exp, tx_exp, mreq, mpop;
   logic [31:0] data_exp, rd;

   always @(posedge clk) begin
      if (!reset) begin
         mq.delete();
         baud = 868; busy = 0; ack_exp = 0; data_exp = 0; tx_exp = 1; e = 0; lat = 868;
         mvalid = 1;
      end else if (mvalid) begin
         mreq = cyc && stb;
         rd = 0;
         case (addr)
            2'd0: rd = (mq.size() == D) ? 32'h8000_0000 : 32'h0;
            2'd1: rd = (mq.size() << 8) | (int'(busy) << 2) | (int'(mq.size() == D) << 1)
                       | int'(mq.size() == 0);
            2'd2: rd = baud;
            default: rd = 0;
         endcase
         ack_exp  = mreq;
         data_exp = (mreq && !we) ? rd : 32'h0;
         mpop = 0;
         if (!busy) mpop = (mq.size() > 0);
         else if (e == 10 * lat - 1) begin
            if (mq.size() > 0) mpop = 1;
            else busy = 0;
         end else e++;
         if (mpop) begin
            cur = mq.pop_front(); lat = baud; e = 0; busy = 1;
         end
         if (mreq && we && addr == 2'd0 && mq.size() < D) mq.push_back(wdata[7:0]);
         if (mreq && we && addr == 2'd2) baud = (wdata[15:0] == 0) ? 1 : int'(wdata[15:0]);
         if (!busy) tx_exp = 1;
         else begin
            k = e / lat;
            tx_exp = (k == 0) ? 1'b0 : (k <= 8) ? cur[k-1] : 1'b1;
         end
      end
      #1;
      if (mvalid) begin
         check("tx", tx, tx_exp);
         check("ack", ack, ack_exp);
         check("rdata", rdata, data_exp);
         check("stall", stall, 0);
      end
   end

   task automatic bus(input logic c, s, w, input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      cyc = c; stb = s; we = w; addr = a; wdata = d;
   endtask

   task automatic idle(input int n);
      repeat (n) bus(0, 0, 0, 2'd0, 32'h0);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      bus(1, 1, 1, a, d);
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
      bus(1, 1, 0, a, 32'h0);
      @(posedge clk); #1;
      check({name, "_ack"}, ack, 1);
      check(name, rdata, exp);
      idle(1);
   endtask

   task automatic pulse_reset();
      @(negedge clk); reset = 0; cyc = 0; stb = 0;
      @(negedge clk); reset = 1;
   endtask

   logic [9:0] a5_line;

   initial begin
      // Reset held two cycles, then STATUS reads empty.
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1;
      rd_chk("reset_status", 2'd1, 32'h0000_0001);
      rd_chk("reset_baud", 2'd2, 32'h0000_0364);

      // Single byte 0xA5 at bit period 4: start, LSB-first data, stop.
      a5_line = 10'b1101001010;
      wr(2'd2, 32'd4);
      wr(2'd0, 32'h0000_00A5);
      @(posedge clk);
      for (int i = 0; i < 40; i++) begin
         idle(1);
         @(posedge clk); #1;
         check("a5_line", tx, a5_line[i/4]);
      end
      idle(2);
      rd_chk("a5_status", 2'd1, 32'h0000_0001);

      // Fill and overflow: 9 accepted (one popped at once), the 10th dropped.
      wr(2'd2, 32'd100);
      for (int b = 1; b <= 10; b++) wr(2'd0, b);
      idle(1);
      rd_chk("full_status", 2'd1, 32'h0000_0806);
      rd_chk("full_txdata", 2'd0, 32'h8000_0000);
      idle(9100);
      rd_chk("drain_status", 2'd1, 32'h0000_0001);

      // Stb without cyc, ignored writes, offset 3 read.
      bus(0, 1, 1, 2'd0, 32'h0000_00FF);
      bus(0, 1, 0, 2'd1, 32'h0);
      wr(2'd1, 32'hFFFF_FFFF);
      wr(2'd3, 32'hFFFF_FFFF);
      idle(2);
      rd_chk("off3", 2'd3, 32'h0);
      rd_chk("stb_only_status", 2'd1, 32'h0000_0001);

      // Divisor change mid-frame only affects the next frame.
      wr(2'd2, 32'd4);
      wr(2'd0, 32'h3C);
      wr(2'd0, 32'hC3);
      idle(10);
      wr(2'd2, 32'd8);
      idle(1);
      rd_chk("baud8", 2'd2, 32'd8);
      idle(130);
      rd_chk("baud_status", 2'd1, 32'h0000_0001);
      wr(2'd2, 32'hABCD_0000);
      idle(1);
      rd_chk("baud0", 2'd2, 32'd1);

      // Reset mid-frame with a request on the same edge.
      wr(2'd2, 32'd4);
      wr(2'd0, 32'h00);
      wr(2'd0, 32'h11);
      idle(8);
      @(negedge clk); reset = 0; cyc = 1; stb = 1; we = 1; addr = 2'd0; wdata = 32'h55;
      @(posedge clk); #1;
      check("rst_tx", tx, 1);
      check("rst_ack", ack, 0);
      @(negedge clk); reset = 1; cyc = 0; stb = 0;
      @(posedge clk); #1;
      check("rst_no_ack", ack, 0);
      rd_chk("rst_status", 2'd1, 32'h0000_0001);
      rd_chk("rst_baud", 2'd2, 32'd868);

      // Randomised traffic, short bit periods.
      wr(2'd2, 32'd3);
      for (int n = 0; n < 400; n++) begin
         int unsigned r;
         logic [1:0]  a;
         logic [31:0] d;
         logic        w;
         r = $urandom_range(0, 99);
         if (r < 2) begin
            pulse_reset();
            wr(2'd2, 32'd3);
         end else begin
            a = 2'($urandom_range(0, 3));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            if (a == 2'd2 && w) d[15:0] = 16'($urandom_range(0, 5));
            bus($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, w, a, d);
            if (r < 40) idle($urandom_range(1, 20));
         end
      end
      idle(600);
      rd_chk("final_status", 2'd1, 32'h0000_0001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/leiwand_rv32_wb_uart_tx.md
Name: leiwand_rv32_wb_uart_tx

Overview:
- Wishbone (pipelined) responder that serialises bytes written by the core onto a UART TX line. It is the peer of the core's bus initiator.
- It sits on the SoC bus beside the internal SRAM/ROM. Its strobe is address-decoded at the SoC level.
- Its read-data, ack and stall outputs are ORed with those of the other responders, so every one of them must be 0 whenever the block is not acknowledging.
- An internal FIFO decouples the core from the serial bit timing.

Parameters:
- MEM_WIDTH, 32, bus data width. Only 32 is supported.
- FIFO_DEPTH, 8, TX FIFO entries. Must be a power of 2, 2..64.
- DEFAULT_BAUD_DIV, 16'd868, bit period in clk cycles after reset.

Ports:
- clk, input, 1, system clock. All logic is on the rising edge.
- reset, input, 1, synchronous reset, active-low. Asserted when 0 and sampled on the rising edge of clk.
- i_wb_addr, input, 2, word offset (byte address bits [3:2]).
- i_wb_data, input, MEM_WIDTH, write data.
- o_wb_data, output, MEM_WIDTH, read data. Non-zero only in an ack cycle.
- i_wb_we, input, 1, 1 = write.
- i_wb_stb, input, 1, strobe (already decoded for this block).
- o_wb_ack, output, 1, one-cycle acknowledge.
- i_wb_cyc, input, 1, bus cycle valid.
- o_wb_stall, output, 1, tied 0.
- o_tx, output, 1, serial line. Idle level is 1.

Behaviour:
- Reset (reset==0 at an edge):
  - o_tx=1, o_wb_ack=0, o_wb_data=0.
  - FIFO empty: count=0, pointers=0.
  - baud_div=DEFAULT_BAUD_DIV, FSM=IDLE.
  - Takes effect at that edge even mid-frame or mid-transaction. A pending ack is dropped.
- Bus access:
  - A request is i_wb_cyc & i_wb_stb sampled at edge E.
  - o_wb_ack=1 for exactly the cycle after E. The side effect is applied at E.
  - Back-to-back requests on consecutive edges each get their own ack on consecutive cycles.
  - If stb is asserted without cyc, there is no ack and no side effect.
  - o_wb_data holds the read value only while o_wb_ack=1, and is 0 otherwise, including for write acks.
- Register map:
  - Offset 0 TXDATA:
    - Write pushes i_wb_data[7:0].
    - Read returns {full, 31'b0}.
  - Offset 1 STATUS (read-only; writes are ignored but acked). Read returns:
    - bit0 = fifo empty
    - bit1 = fifo full
    - bit2 = busy (FSM != IDLE)
    - bits[14:8] = fifo count
    - all other bits 0
  - Offset 2 BAUDDIV:
    - Write sets baud_div=i_wb_data[15:0]. A value of 0 is stored as 1.
    - Read returns {16'b0, baud_div}.
  - Offset 3: reads return 0; writes are ignored but acked.
- FIFO:
  - A push is accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and the FSM pops on the same edge.
  - A push to a full FIFO with no simultaneous pop is silently dropped, is still acked, and leaves contents unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - The bit-period counter is reloaded with the latched divisor (lat_div) at every bit boundary. A bit lasts lat_div cycles.
  - IDLE:
    - o_tx=1.
    - If the FIFO is non-empty at an edge: pop into the shift register, latch lat_div=baud_div, go to START, o_tx=0 from that edge.
  - START: after lat_div cycles go to DATA with bit index 0. o_tx=data[0].
  - DATA:
    - Bits are sent LSB first, each for lat_div cycles.
    - After bit 7 expires go to STOP, o_tx=1.
  - STOP: after lat_div cycles:
    - If the FIFO is non-empty: pop and go directly to START, with lat_div relatched. There are no idle cycles between frames.
    - Otherwise go to IDLE.
- Frame timing:
  - Frame length is 10*lat_div cycles.
  - A BAUDDIV write mid-frame affects only the next frame.
  - Latency: a TXDATA write sampled at E0 into an empty FIFO with an IDLE FSM drives o_tx=0 from edge E0+1.
- o_wb_stall is always 0. The block never back-pressures the bus.

Test Plan:
- Reset values: hold reset=0 for 2 cycles, then read STATUS → ack one cycle after request, data=32'h00000001, o_tx=1 throughout.
- Single byte: BAUDDIV=4, write TXDATA=32'h000000A5 → o_tx low from the edge after the write for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop-bit high for 4 cycles. The frame spans 40 cycles, then STATUS=32'h1.
- FIFO full and drop:
  - BAUDDIV=100, write bytes 0x01..0x0A back-to-back. Each write is acked on the next cycle.
  - Byte 0x01 is popped one cycle after its write, so 9 writes are accepted and the FIFO fills: STATUS bits[14:8]=8, bit1=1.
  - TXDATA read returns 32'h80000000. The 10th byte (0x0A) is dropped.
  - The line emits 0x01..0x09 in order with no idle gaps.
- Bus OR-safety: issue a write and a stb-without-cyc → o_wb_data==0 on every cycle. No ack is generated for the stb-only cycle.
- Baud change mid-frame: with BAUDDIV=4, queue two bytes. During frame 1, write BAUDDIV=8 → frame 1 stays 40 cycles and frame 2 is 80 cycles. A BAUDDIV=0 write reads back 1.
- Reset mid-frame: assert reset=0 during DATA → o_tx=1 at that edge, FIFO empty, BAUDDIV reads 868, and no spurious ack appears after reset deasserts.
